// File: rtl/test_monitor.sv
// Register-file write monitor: per-hart end-of-test detection with settle window,
// pass/fail verdict, timeout, and a shared saturating cycle counter.
module test_monitor #(
  parameter int unsigned NUM_HARTS      = 1,
  parameter int unsigned DONE_REG       = 26,
  parameter int unsigned RESULT_REG     = 27,
  parameter int unsigned TESTNUM_REG    = 3,
  parameter int unsigned SETTLE_CYCLES  = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_HARTS-1:0]      we_i,
  input  logic [5*NUM_HARTS-1:0]    waddr_i,
  input  logic [32*NUM_HARTS-1:0]   wdata_i,
  output logic [NUM_HARTS-1:0]      done_o,
  output logic [NUM_HARTS-1:0]      pass_o,
  output logic [NUM_HARTS-1:0]      timeout_o,
  output logic [32*NUM_HARTS-1:0]   testnum_o,
  output logic                      all_done_o,
  output logic                      all_pass_o,
  output logic [31:0]               cycle_cnt_o
);

  typedef enum logic [1:0] {StRun, StSettle, StPass, StFail} state_e;

  localparam logic [4:0]  DoneIdx    = 5'(DONE_REG);
  localparam logic [4:0]  ResultIdx  = 5'(RESULT_REG);
  localparam logic [4:0]  TestnumIdx = 5'(TESTNUM_REG);
  localparam logic [7:0]  SettleInit = 8'(SETTLE_CYCLES - 1);
  localparam logic [23:0] TmoLast    = 24'(TIMEOUT_CYCLES - 1);

  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cycle_cnt_q <= '0;
    else        cycle_cnt_q <= cycle_cnt_d;
  end

  assign cycle_cnt_o = cycle_cnt_q;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    state_e      state_q, state_d;
    logic [7:0]  settle_q, settle_d;
    logic [23:0] tmo_q, tmo_d;
    logic [31:0] result_q, result_d;
    logic [31:0] testnum_q, testnum_d;
    logic        timeout_q, timeout_d;

    logic [4:0]  addr;
    logic [31:0] data;
    logic        wr_ok, hit_done, hit_result, hit_testnum;

    assign addr        = waddr_i[5*h +: 5];
    assign data        = wdata_i[32*h +: 32];
    // x0 is hardwired, so writes to it never match anything.
    assign wr_ok       = we_i[h] && (addr != 5'd0);
    assign hit_done    = wr_ok && (addr == DoneIdx) && (data == 32'h1);
    assign hit_result  = wr_ok && (addr == ResultIdx);
    assign hit_testnum = wr_ok && (addr == TestnumIdx);

    always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      tmo_d     = tmo_q;
      result_d  = result_q;
      testnum_d = testnum_q;
      timeout_d = timeout_q;
      if (state_q == StRun || state_q == StSettle) begin
        if (hit_result)  result_d  = data;
        if (hit_testnum) testnum_d = data;
      end
      unique case (state_q)
        StRun: begin
          tmo_d = tmo_q + 24'd1;
          // A done write in the expiry cycle takes priority over the timeout.
          if (hit_done) begin
            state_d  = StSettle;
            settle_d = SettleInit;
          end else if (tmo_q == TmoLast) begin
            state_d   = StFail;
            timeout_d = 1'b1;
          end
        end
        StSettle: begin
          // result_d so a write in the last settle cycle still counts.
          if (settle_q == 8'd0) state_d = (result_d == 32'h1) ? StPass : StFail;
          else                  settle_d = settle_q - 8'd1;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q   <= StRun;
        settle_q  <= '0;
        tmo_q     <= '0;
        result_q  <= '0;
        testnum_q <= '0;
        timeout_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        settle_q  <= settle_d;
        tmo_q     <= tmo_d;
        result_q  <= result_d;
        testnum_q <= testnum_d;
        timeout_q <= timeout_d;
      end
    end

    assign done_o[h]            = (state_q == StPass) || (state_q == StFail);
    assign pass_o[h]            = (state_q == StPass);
    assign timeout_o[h]         = timeout_q;
    assign testnum_o[32*h +: 32] = testnum_q;
  end

  assign all_done_o = &done_o;
  assign all_pass_o = all_done_o && (&pass_o);

endmodule
